// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared state type and helper functions for the SAR ADC scanner
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } sar_state_e;

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Returns {found, index} of the lowest set bit at or above position from
    function automatic logic [4:0] first_set_from(input logic [15:0] mask, input int from);
        logic [4:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_tick_gen.sv
// rtl/sar_tick_gen.sv - divides clk down to one SAR step tick every DIV cycles
module sar_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/sar_adc_scanner.sv
// rtl/sar_adc_scanner.sv - multi-channel scan sequencer driving a successive-approximation ADC
module sar_adc_scanner
    import sar_adc_pkg::*;
#(
    parameter int N_BITS = 10,
    parameter int N_CH   = 4,
    parameter int DIV    = 4,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              cmp_in,
    output logic [CH_W-1:0]   ch_sel,
    output logic              sample,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic              eoc,
    output logic [N_BITS-1:0] result_data,
    output logic [CH_W-1:0]   result_ch,
    output logic              overrun
);

    localparam int BW = $clog2(N_BITS);
    localparam logic [N_BITS-1:0] MSB_CODE = {1'b1, {(N_BITS-1){1'b0}}};

    sar_state_e        state;
    logic              pending;
    logic              tick;
    logic [N_CH-1:0]   mask_lat;
    logic [BW-1:0]     bit_idx;
    logic [N_BITS-1:0] sar_code;
    logic [N_BITS-1:0] code_nxt;
    logic [4:0]        launch_sel;
    logic [4:0]        next_sel;
    logic [4:0]        wrap_sel;

    sar_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign launch_sel = first_set_from(16'(ch_mask), 0);
    assign next_sel   = first_set_from(16'(mask_lat), int'(ch_sel) + 1);
    assign wrap_sel   = first_set_from(16'(mask_lat), 0);

    // Decide the current trial bit from the comparator, then trial the next lower bit
    always_comb begin
        code_nxt = sar_code;
        if (!cmp_in) code_nxt[bit_idx] = 1'b0;
        if (bit_idx != '0) code_nxt[bit_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            sample      <= 1'b0;
            eoc         <= 1'b0;
            dac_code    <= '0;
            result_data <= '0;
            result_ch   <= '0;
            ch_sel      <= '0;
            mask_lat    <= '0;
            bit_idx     <= '0;
            sar_code    <= '0;
        end else begin
            eoc <= 1'b0;
            if (start && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        pending <= 1'b1;
                        overrun <= 1'b0;
                    end
                    // A mask that went to zero before the launch tick drops the request
                    if (tick && pending) begin
                        pending <= 1'b0;
                        if (launch_sel[4]) begin
                            mask_lat <= ch_mask;
                            ch_sel   <= CH_W'(launch_sel[3:0]);
                            state    <= SAMPLE;
                            busy     <= 1'b1;
                            sample   <= 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    if (tick) begin
                        state    <= CONVERT;
                        sample   <= 1'b0;
                        dac_code <= MSB_CODE;
                        sar_code <= MSB_CODE;
                        bit_idx  <= BW'(N_BITS - 1);
                    end
                end
                CONVERT: begin
                    if (tick) begin
                        sar_code <= code_nxt;
                        if (bit_idx == '0) begin
                            state    <= DONE;
                            dac_code <= '0;
                        end else begin
                            dac_code <= code_nxt;
                            bit_idx  <= bit_idx - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (tick) begin
                        result_data <= sar_code;
                        result_ch   <= ch_sel;
                        eoc         <= 1'b1;
                        if (next_sel[4]) begin
                            ch_sel <= CH_W'(next_sel[3:0]);
                            state  <= SAMPLE;
                            sample <= 1'b1;
                        end else if (cont) begin
                            ch_sel <= CH_W'(wrap_sel[3:0]);
                            state  <= SAMPLE;
                            sample <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_scanner.sv
// tb/tb_sar_adc_scanner.sv - directed vector bench for sar_adc_scanner
module tb_sar_adc_scanner;

    typedef struct packed {
        logic [3:0]       mask;
        logic [3:0][9:0]  v;
        int               n;
        logic [3:0][1:0]  ch;
        logic [3:0][9:0]  d;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start_a, cont_a, cmp_a;
    logic [3:0] mask_a;
    logic [1:0] ch_sel_a, rch_a;
    logic       sample_a, busy_a, eoc_a, ovr_a;
    logic [9:0] dac_a, res_a;
    logic [9:0] vin_a [4];

    logic       start_b, cont_b, cmp_b;
    logic [3:0] mask_b;
    logic [1:0] ch_sel_b, rch_b;
    logic       sample_b, busy_b, eoc_b, ovr_b;
    logic [1:0] dac_b, res_b;
    logic [1:0] vin_b;

    assign cmp_a = (vin_a[ch_sel_a] >= dac_a);
    assign cmp_b = (vin_b >= dac_b);

    sar_adc_scanner #(.N_BITS(10), .N_CH(4), .DIV(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cont(cont_a), .ch_mask(mask_a),
        .cmp_in(cmp_a), .ch_sel(ch_sel_a), .sample(sample_a), .dac_code(dac_a),
        .busy(busy_a), .eoc(eoc_a), .result_data(res_a), .result_ch(rch_a), .overrun(ovr_a)
    );

    sar_adc_scanner #(.N_BITS(2), .N_CH(4), .DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cont(cont_b), .ch_mask(mask_b),
        .cmp_in(cmp_b), .ch_sel(ch_sel_b), .sample(sample_b), .dac_code(dac_b),
        .busy(busy_b), .eoc(eoc_b), .result_data(res_b), .result_ch(rch_b), .overrun(ovr_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   q_ch[$];
    int   q_d[$];
    int   q_sel[$];
    int   busy_cyc_a = 0, eoc_cyc_a = 0, busy_cyc_b = 0, eoc_cyc_b = 0;
    int   res_last_b = 0;
    logic busy_q_a = 1'b0, sample_q_a = 1'b0, busy_q_b = 1'b0;

    always @(negedge clk) begin
        busy_q_a   <= busy_a;
        sample_q_a <= sample_a;
        busy_q_b   <= busy_b;
        if (busy_a && !busy_q_a) busy_cyc_a <= cyc;
        if (sample_a && !sample_q_a) q_sel.push_back(int'(ch_sel_a));
        if (eoc_a) begin
            q_ch.push_back(int'(rch_a));
            q_d.push_back(int'(res_a));
            eoc_cyc_a <= cyc;
        end
        if (busy_b && !busy_q_b) busy_cyc_b <= cyc;
        if (eoc_b) begin
            res_last_b <= int'(res_b);
            eoc_cyc_b  <= cyc;
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt [5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_busy_a(input logic lvl, input int maxc, input string name);
        int k;
        k = 0;
        while ((busy_a !== lvl) && (k < maxc)) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(busy_a), int'(lvl));
    endtask

    task automatic pulse_a(input logic [3:0] m);
        @(negedge clk);
        mask_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int base, sbase, seen;
        for (int i = 0; i < 4; i++) vin_a[i] = vt[k].v[i];
        base  = q_ch.size();
        sbase = q_sel.size();
        pulse_a(vt[k].mask);
        if (vt[k].n == 0) begin
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy_a) seen = 1;
            end
            check($sformatf("v%0d_zero_mask_busy", k), seen, 0);
            check($sformatf("v%0d_zero_mask_eocs", k), q_ch.size() - base, 0);
        end else begin
            wait_busy_a(1'b1, 20, $sformatf("v%0d_busy_rise", k));
            wait_busy_a(1'b0, 300, $sformatf("v%0d_busy_fall", k));
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_eoc_count", k), q_ch.size() - base, vt[k].n);
            for (int i = 0; i < vt[k].n; i++) begin
                if (base + i < q_ch.size()) begin
                    check($sformatf("v%0d_ch[%0d]", k, i), q_ch[base+i], int'(vt[k].ch[i]));
                    check($sformatf("v%0d_data[%0d]", k, i), q_d[base+i], int'(vt[k].d[i]));
                end
            end
            check($sformatf("v%0d_sampled_count", k), q_sel.size() - sbase, vt[k].n);
            for (int i = 0; i < vt[k].n; i++) begin
                if (sbase + i < q_sel.size())
                    check($sformatf("v%0d_sampled[%0d]", k, i), q_sel[sbase+i], int'(vt[k].ch[i]));
            end
            if (vt[k].n == 1)
                check($sformatf("v%0d_latency", k), eoc_cyc_a - busy_cyc_a, 48);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int base, k, seen;

        vt[0] = {4'b0001, {10'd0, 10'd0, 10'd0, 10'd300}, 32'd1,
                 {2'd0, 2'd0, 2'd0, 2'd0}, {10'd0, 10'd0, 10'd0, 10'd300}};
        vt[1] = {4'b1010, {10'd1023, 10'd444, 10'd0, 10'd555}, 32'd2,
                 {2'd0, 2'd0, 2'd3, 2'd1}, {10'd0, 10'd0, 10'd1023, 10'd0}};
        vt[2] = {4'b1111, {10'd1000, 10'd511, 10'd512, 10'd1}, 32'd4,
                 {2'd3, 2'd2, 2'd1, 2'd0}, {10'd1000, 10'd511, 10'd512, 10'd1}};
        vt[3] = {4'b0100, {10'd0, 10'd682, 10'd0, 10'd0}, 32'd1,
                 {2'd0, 2'd0, 2'd0, 2'd2}, {10'd0, 10'd0, 10'd0, 10'd682}};
        vt[4] = {4'b0000, {10'd5, 10'd5, 10'd5, 10'd5}, 32'd0,
                 {2'd0, 2'd0, 2'd0, 2'd0}, {10'd0, 10'd0, 10'd0, 10'd0}};

        reset   = 1'b0;
        start_a = 1'b0; cont_a = 1'b0; mask_a = '0;
        start_b = 1'b0; cont_b = 1'b0; mask_b = '0; vin_b = '0;
        for (int i = 0; i < 4; i++) vin_a[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_sample", int'(sample_a), 0);
        check("rst_eoc", int'(eoc_a), 0);
        check("rst_dac", int'(dac_a), 0);
        check("rst_result", int'(res_a), 0);
        check("rst_result_ch", int'(rch_a), 0);
        check("rst_ch_sel", int'(ch_sel_a), 0);
        check("rst_overrun", int'(ovr_a), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Continuous scan over ch0/ch2, cont dropped after the third result
        vin_a[0] = 10'd100; vin_a[2] = 10'd777;
        cont_a = 1'b1;
        base = q_ch.size();
        pulse_a(4'b0101);
        k = 0;
        while ((q_ch.size() - base < 3) && (k < 1000)) begin
            @(negedge clk);
            k++;
        end
        cont_a = 1'b0;
        wait_busy_a(1'b0, 300, "cont_busy_fall");
        repeat (60) @(negedge clk);
        check("cont_eoc_count", q_ch.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < q_ch.size()) begin
                check($sformatf("cont_ch[%0d]", i), q_ch[base+i], (i % 2 == 0) ? 0 : 2);
                check($sformatf("cont_data[%0d]", i), q_d[base+i], (i % 2 == 0) ? 100 : 777);
            end
        end

        // Start during CONVERT sets overrun without disturbing the scan
        vin_a[0] = 10'd300;
        base = q_ch.size();
        pulse_a(4'b0001);
        wait_busy_a(1'b1, 20, "ovr_busy_rise");
        repeat (10) @(negedge clk);
        check("ovr_before", int'(ovr_a), 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("ovr_set", int'(ovr_a), 1);
        wait_busy_a(1'b0, 100, "ovr_busy_fall");
        repeat (2) @(negedge clk);
        check("ovr_eoc_count", q_ch.size() - base, 1);
        if (q_d.size() > base) check("ovr_data", q_d[base], 300);
        check("ovr_sticky", int'(ovr_a), 1);
        pulse_a(4'b0001);
        check("ovr_cleared", int'(ovr_a), 0);
        wait_busy_a(1'b1, 20, "ovr2_busy_rise");
        wait_busy_a(1'b0, 100, "ovr2_busy_fall");
        repeat (2) @(negedge clk);

        // Asynchronous reset while trialling bit 5 of code 300
        pulse_a(4'b0001);
        wait_busy_a(1'b1, 20, "rst_mid_busy_rise");
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_trial_code", int'(dac_a), 288);
        base = q_ch.size();
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy_a), 0);
        check("rst_mid_dac", int'(dac_a), 0);
        check("rst_mid_sample", int'(sample_a), 0);
        check("rst_mid_eoc", int'(eoc_a), 0);
        check("rst_mid_result", int'(res_a), 0);
        check("rst_mid_ch_sel", int'(ch_sel_a), 0);
        check("rst_mid_overrun", int'(ovr_a), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vin_a[0] = 10'd700;
        pulse_a(4'b0001);
        wait_busy_a(1'b1, 20, "rst_post_busy_rise");
        wait_busy_a(1'b0, 100, "rst_post_busy_fall");
        repeat (2) @(negedge clk);
        check("rst_post_eoc_count", q_ch.size() - base, 1);
        if (q_d.size() > base) check("rst_post_data", q_d[base], 700);

        // Fastest configuration: DIV=1, 2-bit codes
        for (int v = 0; v < 4; v++) begin
            vin_b = 2'(v);
            @(negedge clk);
            mask_b  = 4'b0001;
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            k = 0;
            while (!busy_b && k < 10) begin @(negedge clk); k++; end
            k = 0;
            while (busy_b && k < 20) begin @(negedge clk); k++; end
            repeat (2) @(negedge clk);
            check($sformatf("b%0d_busy_idle", v), int'(busy_b), 0);
            check($sformatf("b%0d_data", v), res_last_b, v);
            check($sformatf("b%0d_latency", v), eoc_cyc_b - busy_cyc_b, 4);
        end
        check("b_result_ch", int'(rch_b), 0);
        check("b_ch_sel", int'(ch_sel_b), 0);
        check("b_sample_idle", int'(sample_b), 0);
        check("b_overrun", int'(ovr_b), 0);
        @(negedge clk);
        mask_b  = 4'b0000;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_b) seen = 1;
        end
        check("b_zero_mask_busy", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_adc_scanner.md
SAR_ADC_SCANNER -- requirements
Module: sar_adc_scanner

Interface
REQ-001 Parameter N_BITS, default 10: conversion resolution in bits, legal range 2..16.
REQ-002 Parameter N_CH, default 4: number of analog channels, legal range 1..16.
REQ-003 Parameter DIV, default 4: clk cycles per SAR step (tick), legal range >=1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-006 start  input  1  level-sampled request to begin a scan; acted on as a pending request.
REQ-007 cont  input  1  continuous mode; when 1 at scan end, the scan restarts without a new start.
REQ-008 ch_mask  input  N_CH  enabled channels; latched at scan launch.
REQ-009 cmp_in  input  1  comparator result, 1 when held input >= DAC voltage for dac_code.
REQ-010 ch_sel  output  clog2(N_CH) (min 1)  channel currently routed to the sample-and-hold.
REQ-011 sample  output  1  sample-and-hold track command.
REQ-012 dac_code  output  N_BITS  current SAR trial code.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 eoc  output  1  one-clk pulse when a channel result is valid.
REQ-015 result_data  output  N_BITS  conversion result, valid while eoc=1 and held until the next eoc.
REQ-016 result_ch  output  clog2(N_CH)  channel index of result_data.
REQ-017 overrun  output  1  sticky flag: start asserted while busy.

Function
REQ-018 Tick generator: counter runs 0..DIV-1 and wraps; tick=1 in the cycle where counter==DIV-1; DIV=1 gives a tick every cycle.
REQ-019 FSM states: IDLE, SAMPLE, CONVERT, DONE; transitions occur only on tick cycles, except those stated otherwise.
REQ-020 IDLE: a rising clk with start=1 and ch_mask!=0 sets pending; at the next tick, ch_mask is latched, ch_sel = lowest set bit, pending clears, and the FSM enters SAMPLE.
REQ-021 start with ch_mask==0 is ignored; pending is not set.
REQ-022 SAMPLE lasts exactly one tick with sample=1; the FSM then enters CONVERT with dac_code = 1<<(N_BITS-1) and bit index = N_BITS-1.
REQ-023 CONVERT, each tick: if cmp_in=0, clear the trial bit at the current index; then set the next lower bit; the FSM leaves CONVERT after bit 0 is decided, giving N_BITS ticks.
REQ-024 DONE, on the tick: result_data = final dac_code, result_ch = ch_sel, and eoc=1 for one clk cycle.
REQ-025 After DONE, the FSM moves to SAMPLE for the next higher set bit in the latched mask.
REQ-026 If none remains: with cont=1, the FSM wraps to the lowest set bit of the latched mask; otherwise it goes to IDLE.
REQ-027 Per-channel latency is N_BITS+2 ticks (SAMPLE + N_BITS CONVERT + DONE), i.e. (N_BITS+2)*DIV clk.
REQ-028 ch_mask changes during a scan have no effect until the next launch; cont is sampled at each DONE.
REQ-029 start=1 while busy sets overrun; overrun clears only on a start accepted from IDLE.
REQ-030 Clearing cont mid-scan lets the current scan finish, then the FSM goes to IDLE.
REQ-031 Outputs are registered; dac_code=0 and sample=0 outside SAMPLE and CONVERT.

Reset
REQ-032 On reset=0: FSM=IDLE and tick counter=0; pending, overrun, busy, sample, eoc=0; dac_code, result_data, result_ch, ch_sel=0.
REQ-033 Reset mid-conversion aborts the conversion without producing eoc; the first tick after release is DIV cycles later.

Structure
REQ-034 The FSM state enum, the CH_W = max(1, clog2(N_CH)) width function and the first-set-bit-from-index function reside in package sar_adc_pkg.
REQ-035 The tick generator is sub-module sar_tick_gen (parameter DIV; ports clk, reset, tick).

Verification
REQ-036 N_BITS=10, N_CH=4, DIV=4, ideal comparator, ch0 input 300, mask=0001, start pulse -> one eoc with result_data=300, result_ch=0, 48 clk after launch tick, then busy=0.
REQ-037 mask=1010, inputs ch1=0, ch3=1023 -> eoc order ch1 (0) then ch3 (1023); ch0 and ch2 are never selected.
REQ-038 cont=1, mask=0101 -> eoc sequence ch0, ch2, ch0, ch2...; cont dropped after the 3rd eoc -> the 4th eoc is ch2, then IDLE.
REQ-039 start pulsed during CONVERT -> overrun=1 and the scan is unchanged; the next start from IDLE clears overrun.
REQ-040 reset=0 at CONVERT bit 5 -> all outputs zero the same cycle, no eoc; a new start converts correctly.
REQ-041 DIV=1, N_BITS=2, input 2 -> result_data=2 four clk after launch; start with mask=0000 -> busy stays 0.
